// File: rtl/pe_seq_ctrl.sv
// ============================================================================
// Module      : pe_seq_ctrl
// Description : Job sequencer for a 4-weight processing element: loads the
//               weight buffer, then steps each pixel through 4 weight phases.
//               Optional busy-cycle counter under PE_SEQ_CTRL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_seq_ctrl #(
    parameter int PIX_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PIX_W-1:0]        num_pix,
    input  logic                    wt_valid,
    input  logic signed [7:0]       wt_data,
    output logic                    wt_ready,
    input  logic                    px_valid,
    output logic                    px_ready,
    output logic signed [7:0]       weight_load,
    output logic                    weight_load_en,
    output logic [1:0]              weight_load_sel,
    output logic                    pipe_en,
    output logic                    pe_en,
    output logic [1:0]              weight_sel,
    output logic                    prod_valid,
    output logic [1:0]              prod_tag,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] c_LAST_IDX = 2'd3;

    state_t             r_state;
    logic [1:0]         r_beat;
    logic [1:0]         r_phase;
    logic               r_inflight;
    logic [PIX_W-1:0]   r_pix_rem;
    logic               r_done;
    logic               r_prod_valid;
    logic [1:0]         r_prod_tag;

    logic               w_in_load;
    logic               w_in_run;
    logic               w_wt_hs;
    logic               w_px_ready;
    logic               w_px_hs;
    logic               w_last_phase;

    assign w_in_load    = (r_state == S_LOAD);
    assign w_in_run     = (r_state == S_RUN);
    assign w_wt_hs      = w_in_load & wt_valid;
    assign w_last_phase = r_inflight & (r_phase == c_LAST_IDX);
    // A new pixel may overlap the final phase of the previous one.
    assign w_px_ready   = w_in_run & (r_pix_rem != '0) & (~r_inflight | w_last_phase);
    assign w_px_hs      = w_px_ready & px_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_beat       <= 2'd0;
            r_phase      <= 2'd0;
            r_inflight   <= 1'b0;
            r_pix_rem    <= '0;
            r_done       <= 1'b0;
            r_prod_valid <= 1'b0;
            r_prod_tag   <= 2'd0;
        end else begin
            r_done       <= 1'b0;
            r_prod_valid <= r_inflight;
            r_prod_tag   <= r_phase;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pix_rem <= num_pix;
                        r_beat    <= 2'd0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_wt_hs) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == c_LAST_IDX) begin
                            r_state <= (r_pix_rem == '0) ? S_DRAIN : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_px_hs) begin
                        r_inflight <= 1'b1;
                        r_phase    <= 2'd0;
                        r_pix_rem  <= r_pix_rem - PIX_W'(1);
                    end else if (w_last_phase) begin
                        r_inflight <= 1'b0;
                        r_phase    <= 2'd0;
                        if (r_pix_rem == '0) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (r_inflight) begin
                        r_phase <= r_phase + 2'd1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wt_ready        = w_in_load;
    assign weight_load     = w_in_load ? wt_data : 8'sd0;
    assign weight_load_en  = w_wt_hs;
    assign weight_load_sel = w_in_load ? r_beat : 2'd0;
    assign px_ready        = w_px_ready;
    assign pipe_en         = w_px_hs;
    assign pe_en           = r_inflight;
    assign weight_sel      = r_phase;
    assign prod_valid      = r_prod_valid;
    assign prod_tag        = r_prod_tag;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;

`ifdef PE_SEQ_CTRL_PERF_CNT_EN
    logic [15:0] r_busy_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cycles <= 16'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_busy_cycles <= 16'd0;
        end else if (busy && (r_busy_cycles != 16'hFFFF)) begin
            r_busy_cycles <= r_busy_cycles + 16'd1;
        end
    end

    assign busy_cycles = r_busy_cycles;
`else
    assign busy_cycles = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: job driver predicts event timing from the
// protocol rules, a negedge monitor pops and compares DUT events.
`default_nettype none

module tb_pe_seq_ctrl;
    localparam int PIX_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [PIX_W-1:0]   num_pix = '0;
    logic               wt_valid = 1'b0;
    logic signed [7:0]  wt_data = '0;
    logic               px_valid = 1'b0;
    logic               wt_ready, px_ready, weight_load_en, pipe_en, pe_en;
    logic signed [7:0]  weight_load;
    logic [1:0]         weight_load_sel, weight_sel, prod_tag;
    logic               prod_valid, busy, done;
    logic [15:0]        busy_cycles;

    pe_seq_ctrl #(.PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_pix(num_pix),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .px_valid(px_valid), .px_ready(px_ready),
        .weight_load(weight_load), .weight_load_en(weight_load_en),
        .weight_load_sel(weight_load_sel), .pipe_en(pipe_en), .pe_en(pe_en),
        .weight_sel(weight_sel), .prod_valid(prod_valid), .prod_tag(prod_tag),
        .busy(busy), .done(done), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [7:0] d; logic [1:0] s; } ev_t;
    typedef struct { int c; int bc; } dn_t;

    ev_t wq[$];
    ev_t pq[$];
    int  pipeq[$];
    dn_t dq[$];

    int checks = 0;
    int errors = 0;

    int               j_wgap[4];
    logic signed [7:0] j_w[4];

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        wq.delete();
        pq.delete();
        pipeq.delete();
        dq.delete();
    endtask

    // Busy cycles span start+1 .. done-1 when the counter is built in.
    function automatic int exp_bc(input int s, input int done_c);
`ifdef PE_SEQ_CTRL_PERF_CNT_EN
        return done_c - s - 1;
`else
        return 0;
`endif
    endfunction

    task automatic check_quiet(input string nm);
        chk({busy, done, prod_valid, pe_en, pipe_en, px_ready, wt_ready, weight_load_en} == 8'd0,
            {nm, "_ctl"}, {busy, done, prod_valid, pe_en, pipe_en, px_ready, wt_ready, weight_load_en}, 0);
        chk(busy_cycles == 16'd0 && weight_sel == 2'd0 && prod_tag == 2'd0 && weight_load_sel == 2'd0,
            {nm, "_data"}, {busy_cycles, weight_sel, prod_tag, weight_load_sel}, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        wt_valid = 1'b0;
        px_valid = 1'b0;
        flush();
        step();
        check_quiet("post_reset");
        rst = 1'b0;
    endtask

    task automatic set_weights(input bit rnd, input int gmax);
        for (int b = 0; b < 4; b++) begin
            j_w[b]    = rnd ? 8'($urandom) : 8'(b + 1);
            j_wgap[b] = $urandom_range(0, gmax);
        end
    endtask

    // pmode >= 0: fixed idle gap before every pixel; pmode < 0: random gaps.
    task automatic run_job(input int n, input int pmode, input int abort_px);
        int s, rr, a_prev, expa, g, tmo;
        s = cyc;
        start = 1'b1;
        num_pix = PIX_W'(n);
        step();
        start = 1'b0;
        num_pix = PIX_W'($urandom);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < j_wgap[b]; i++) begin
                wt_valid = 1'b0;
                wt_data = 8'($urandom);
                step();
            end
            wt_valid = 1'b1;
            wt_data = j_w[b];
            wq.push_back('{cyc, j_w[b], 2'(b)});
            if (b > 0) start = 1'($urandom_range(0, 1));
            step();
        end
        wt_valid = 1'b0;
        start = 1'b0;
        rr = cyc;
        a_prev = 0;
        if (n == 0) begin
            dq.push_back('{rr + 1, exp_bc(s, rr + 1)});
        end else begin
            for (int k = 0; k < n; k++) begin
                g = (pmode >= 0) ? pmode :
                    (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
                for (int i = 0; i < g; i++) begin
                    px_valid = 1'b0;
                    if (k > 0) begin
                        start = 1'($urandom_range(0, 1));
                        num_pix = PIX_W'($urandom);
                    end
                    if (k == 0 || cyc >= a_prev + 5)
                        chk(px_ready === 1'b1 && pe_en === 1'b0, "gap_idle", {px_ready, pe_en}, 2'b10);
                    step();
                end
                start = 1'b0;
                px_valid = 1'b1;
                expa = (k == 0) ? cyc : ((a_prev + 4 > cyc) ? a_prev + 4 : cyc);
                pipeq.push_back(expa);
                for (int t = 0; t < 4; t++) pq.push_back('{expa + 2 + t, 8'd0, 2'(t)});
                tmo = 0;
                while (!px_ready && tmo < 20) begin
                    step();
                    tmo++;
                end
                if (!px_ready) begin
                    chk(1'b0, "px_ready_timeout", 0, 1);
                    apply_reset();
                    return;
                end
                chk(cyc == expa, "px_accept_cycle", cyc, expa);
                a_prev = cyc;
                step();
                px_valid = 1'b0;
                if (k + 1 == abort_px) begin
                    step();
                    apply_reset();
                    repeat (8) step();
                    return;
                end
            end
            dq.push_back('{a_prev + 6, exp_bc(s, a_prev + 6)});
        end
        tmo = 0;
        while (dq.size() != 0 && tmo < 30) begin
            step();
            tmo++;
        end
        if (dq.size() != 0) begin
            chk(1'b0, "done_timeout", 0, 1);
            apply_reset();
            return;
        end
        chk(wq.size() + pq.size() + pipeq.size() == 0, "leftover_events",
            wq.size() + pq.size() + pipeq.size(), 0);
        step();
    endtask

    always @(negedge clk) begin
        ev_t e;
        dn_t d;
        int  pc;
        if (!rst) begin
            if (weight_load_en) begin
                if (wq.size() == 0) chk(1'b0, "unexpected_wload", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk(cyc == e.c, "wload_cycle", cyc, e.c);
                    chk(weight_load == e.d && weight_load_sel == e.s, "wload_data",
                        {weight_load, weight_load_sel}, {e.d, e.s});
                end
            end
            if (!wt_ready)
                chk(weight_load == 8'sd0 && weight_load_sel == 2'd0 && !weight_load_en,
                    "wload_idle", {weight_load, weight_load_sel, weight_load_en}, 0);
            if (pipe_en) begin
                if (pipeq.size() == 0) chk(1'b0, "unexpected_pipe_en", 1, 0);
                else begin
                    pc = pipeq.pop_front();
                    chk(cyc == pc, "pipe_en_cycle", cyc, pc);
                end
            end
            if (prod_valid) begin
                if (pq.size() == 0) chk(1'b0, "unexpected_prod_valid", 1, 0);
                else begin
                    e = pq.pop_front();
                    chk(cyc == e.c && prod_tag == e.s, "prod_event",
                        {cyc, 6'd0, prod_tag}, {e.c, 6'd0, e.s});
                end
            end
            if (done) begin
                if (dq.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
                else begin
                    d = dq.pop_front();
                    chk(cyc == d.c, "done_cycle", cyc, d.c);
                    chk(int'(busy_cycles) == d.bc, "busy_cycles", busy_cycles, d.bc);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check_quiet("reset");
        rst = 1'b0;
        step();

        set_weights(1'b0, 0);
        run_job(0, 0, -1);
        set_weights(1'b1, 0);
        run_job(3, 0, -1);
        set_weights(1'b1, 0);
        run_job(2, 5, -1);
        set_weights(1'b1, 0);
        for (int b = 0; b < 4; b++) j_wgap[b] = 1;
        run_job(2, 0, -1);
        set_weights(1'b1, 0);
        run_job(1, 0, -1);
        set_weights(1'b1, 0);
        run_job(4, 0, 2);
        set_weights(1'b1, 0);
        run_job(1, 0, -1);
        set_weights(1'b1, 1);
        run_job(255, 0, -1);
        for (int j = 0; j < 20; j++) begin
            set_weights(1'b1, 2);
            run_job($urandom_range(0, 6), -1, -1);
        end
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter PIX_W, default 8, width of the pixel-count field.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle job launch pulse.
REQ-005 SHALL have port num_pix  input  PIX_W  number of pixels in the job; sampled when start is accepted.
REQ-006 SHALL have ports wt_valid input 1, wt_data input 8 (signed), wt_ready output 1; weight stream, 4 beats per job.
REQ-007 SHALL have ports px_valid input 1, px_ready output 1; pixel handshake, data goes straight to the PE imap input.
REQ-008 SHALL have ports weight_load output 8, weight_load_en output 1, weight_load_sel output 2; PE weight-buffer write.
REQ-009 SHALL have ports pipe_en output 1, pe_en output 1, weight_sel output 2; PE compute control.
REQ-010 SHALL have ports prod_valid output 1, prod_tag output 2; these flag the PE product register and give its weight index.
REQ-011 SHALL have ports busy output 1, done output 1 (one-cycle pulse), busy_cycles output 16.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, RUN, DRAIN.
REQ-013 IDLE->LOAD SHALL occur on start; start outside IDLE SHALL be ignored.
REQ-014 In LOAD: wt_ready=1; weight_load=wt_data; weight_load_en=wt_valid&wt_ready; weight_load_sel=beat count 0..3.
REQ-015 The 4th accepted weight beat SHALL move the FSM to RUN, or to DRAIN if the latched num_pix==0.
REQ-016 In RUN, each pixel SHALL take 4 phases: the accept cycle T has pipe_en=px_valid&px_ready; cycles T+1..T+4 have pe_en=1 with weight_sel=0,1,2,3.
REQ-017 px_ready SHALL be 1 in RUN when pixels remain and either no pixel is in flight or the current phase is weight_sel=3; back-to-back pixels then give 1 pixel per 4 cycles.
REQ-018 pe_en SHALL stay 0 while the controller waits for px_valid with no pixel in flight.
REQ-019 prod_valid/prod_tag SHALL equal pe_en/weight_sel delayed one cycle (the PE product register latency).
REQ-020 After the weight_sel=3 phase of the last pixel, the FSM SHALL enter DRAIN for exactly 1 cycle; prod_valid for tag 3 appears in that cycle.
REQ-021 DRAIN->IDLE SHALL pulse done=1 for one cycle as IDLE is entered.
REQ-022 The pixel counter SHALL be PIX_W bits, decrement on each accepted pixel and not wrap; num_pix=2^PIX_W-1 SHALL be supported.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Outside LOAD, all weight_load* outputs SHALL be 0; outside RUN, pipe_en and px_ready SHALL be 0.

Reset
REQ-025 When rst=1 at a clock edge: FSM->IDLE, all counters 0, all outputs 0 (including busy, done, prod_valid and busy_cycles) the next cycle.
REQ-026 Reset mid-job SHALL abort the job without a done pulse; PE weight contents are left undefined.

Configuration
REQ-027 With macro PE_SEQ_CTRL_PERF_CNT_EN defined, busy_cycles SHALL clear on accepted start, then count each cycle with busy=1, and saturate at 16'hFFFF.
REQ-028 With the macro undefined, busy_cycles SHALL be tied to 0 and no counter flops SHALL exist; the port list is unchanged.

Verification
REQ-029 start, num_pix=0, weights 1,2,3,4 back-to-back -> weight_load_sel 0..3 over 4 cycles, DRAIN, done 1 cycle later, zero pe_en cycles.
REQ-030 num_pix=3, px_valid held 1 -> pipe_en pulses 4 cycles apart, 12 pe_en cycles with weight_sel 0,1,2,3 repeating, prod_valid lagging 1 cycle, then done.
REQ-031 num_pix=2, px_valid low for 5 cycles between pixels -> pe_en=0 and px_ready=1 during the gap, with no extra prod_valid.
REQ-032 wt_valid toggling 1,0,1,0... -> only valid beats are written, weight_load_sel advances only on handshake.
REQ-033 rst asserted during RUN of a num_pix=4 job -> next cycle all outputs 0, state IDLE, no done; a new start runs cleanly.
REQ-034 With PE_SEQ_CTRL_PERF_CNT_EN, job num_pix=1 without stalls -> busy_cycles=10 at done (4 LOAD + 5 RUN + 1 DRAIN); without the macro it reads 0.
